// File: rtl/bus_ctrl_pkg.sv
// Shared definitions for the multi-port bus controller: FSM encoding, error word,
// and the system address map used as the default region table.
package bus_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

  localparam logic [31:0] RAM_BASE   = 32'h0000_0000;
  localparam logic [31:0] RAM_MASK   = 32'hFFFC_0000;
  localparam logic [31:0] GPIOA_BASE = 32'h8000_0000;
  localparam logic [31:0] GPIOB_BASE = 32'h8000_0010;
  localparam logic [31:0] GPIO_MASK  = 32'hFFFF_FFF0;
  localparam logic [31:0] TIMER_BASE = 32'h8000_0100;
  localparam logic [31:0] TIMER_MASK = 32'hFFFF_FF00;

  // Region 0 is RAM, 1 GPIOA, 2 GPIOB, 3 the timer block.
  localparam logic [127:0] DEF_SLV_BASE = {TIMER_BASE, GPIOB_BASE, GPIOA_BASE, RAM_BASE};
  localparam logic [127:0] DEF_SLV_MASK = {TIMER_MASK, GPIO_MASK, GPIO_MASK, RAM_MASK};

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational priority address decoder: the lowest-index region whose
// (addr & mask) equals its base wins; produces a one-hot select and a hit flag.
module bus_addr_decode
  import bus_ctrl_pkg::*;
#(
  parameter int                         N_SLAVES = 4,
  parameter int                         ADDR_W   = 32,
  parameter logic [N_SLAVES*ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [N_SLAVES*ADDR_W-1:0] SLV_MASK = '0
) (
  input  logic [ADDR_W-1:0]   addr_i,
  output logic [N_SLAVES-1:0] sel_o,
  output logic                hit_o
);

  // Scanning from the top down lets lower-index matches overwrite higher ones.
  always_comb begin
    sel_o = '0;
    hit_o = 1'b0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((addr_i & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
        sel_o    = '0;
        sel_o[i] = 1'b1;
        hit_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_controller_mp.sv
// Multi-port bus controller: decodes CPU accesses onto N slaves with a registered
// request/ready handshake, decode-miss and timeout errors. Optional BUS_CTRL_STATS_EN adds access/error counters.
module bus_controller_mp
  import bus_ctrl_pkg::*;
#(
  parameter int                         N_SLAVES    = 4,
  parameter int                         ADDR_W      = 32,
  parameter int                         DATA_W      = 32,
  parameter logic [N_SLAVES*ADDR_W-1:0] SLV_BASE    = (N_SLAVES*ADDR_W)'(DEF_SLV_BASE),
  parameter logic [N_SLAVES*ADDR_W-1:0] SLV_MASK    = (N_SLAVES*ADDR_W)'(DEF_SLV_MASK),
  parameter int                         TIMEOUT_CYC = 16,
  parameter logic [31:0]                ERR_DATA    = ERR_DATA_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         bus_re,
  input  logic [DATA_W/8-1:0]          bus_we,
  input  logic [ADDR_W-1:0]            bus_addr,
  input  logic [DATA_W-1:0]            bus_wdata,
  output logic [DATA_W-1:0]            bus_rdata,
  output logic                         bus_stall,
  output logic                         bus_err,
  output logic [N_SLAVES-1:0]          slv_ce,
  output logic [DATA_W/8-1:0]          slv_we,
  output logic [ADDR_W-1:0]            slv_addr,
  output logic [DATA_W-1:0]            slv_wdata,
  input  logic [N_SLAVES*DATA_W-1:0]   slv_rdata,
`ifdef BUS_CTRL_STATS_EN
  output logic [31:0]                  stat_acc_cnt,
  output logic [31:0]                  stat_err_cnt,
`endif
  input  logic [N_SLAVES-1:0]          slv_ready
);

  localparam int                BE_W     = DATA_W / 8;
  localparam int                CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [DATA_W-1:0] ERR_WORD = DATA_W'(ERR_DATA);

  state_e              state_q, state_d;
  logic [N_SLAVES-1:0] slv_ce_q, slv_ce_d;
  logic [BE_W-1:0]     slv_we_q, slv_we_d;
  logic [ADDR_W-1:0]   slv_addr_q, slv_addr_d;
  logic [DATA_W-1:0]   slv_wdata_q, slv_wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                req;
  logic [N_SLAVES-1:0] dec_sel;
  logic                dec_hit;
  logic                ready_hit;
  logic [DATA_W-1:0]   rdata_sel;

  bus_addr_decode #(
    .N_SLAVES (N_SLAVES),
    .ADDR_W   (ADDR_W),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_decode (
    .addr_i (bus_addr),
    .sel_o  (dec_sel),
    .hit_o  (dec_hit)
  );

  assign req       = bus_re | (|bus_we);
  assign bus_stall = req & (state_q != RESP) & ~rst;

  // slv_ce_q doubles as the latched slave select while in ACCESS.
  assign ready_hit = |(slv_ready & slv_ce_q);

  always_comb begin
    rdata_sel = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (slv_ce_q[i]) rdata_sel = rdata_sel | slv_rdata[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d     = state_q;
    slv_ce_d    = slv_ce_q;
    slv_we_d    = slv_we_q;
    slv_addr_d  = slv_addr_q;
    slv_wdata_d = slv_wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (dec_hit) begin
            slv_ce_d    = dec_sel;
            slv_we_d    = bus_we;
            slv_addr_d  = bus_addr;
            slv_wdata_d = bus_wdata;
            cnt_d       = '0;
            state_d     = ACCESS;
          end else begin
            rdata_d = ERR_WORD;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      ACCESS: begin
        if (ready_hit) begin
          rdata_d  = rdata_sel;
          err_d    = 1'b0;
          slv_ce_d = '0;
          slv_we_d = '0;
          state_d  = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d  = ERR_WORD;
          err_d    = 1'b1;
          slv_ce_d = '0;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      slv_ce_q    <= '0;
      slv_we_q    <= '0;
      slv_addr_q  <= '0;
      slv_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      slv_ce_q    <= slv_ce_d;
      slv_we_q    <= slv_we_d;
      slv_addr_q  <= slv_addr_d;
      slv_wdata_q <= slv_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign slv_ce    = slv_ce_q;
  assign slv_we    = slv_we_q;
  assign slv_addr  = slv_addr_q;
  assign slv_wdata = slv_wdata_q;
  assign bus_rdata = rdata_q;
  assign bus_err   = err_q;

`ifdef BUS_CTRL_STATS_EN
  logic        resp_entry;
  logic [31:0] stat_acc_q, stat_err_q;

  assign resp_entry = (state_d == RESP) && (state_q != RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_acc_q <= '0;
      stat_err_q <= '0;
    end else if (resp_entry) begin
      stat_acc_q <= sat_inc32(stat_acc_q);
      if (err_d) stat_err_q <= sat_inc32(stat_err_q);
    end
  end

  assign stat_acc_cnt = stat_acc_q;
  assign stat_err_cnt = stat_err_q;
`endif

endmodule

// File: tb/tb_bus_controller_mp.sv
// Randomized self-checking bench for bus_controller_mp against a transaction-level
// model; checks the stats counters when BUS_CTRL_STATS_EN is defined.
module tb_bus_controller_mp;

  localparam int          N   = 4;
  localparam int          AW  = 32;
  localparam int          DW  = 32;
  localparam int          TO  = 16;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  // Region 1 is an alias overlapping the bottom of RAM so priority can be observed.
  localparam logic [AW-1:0] TB_BASE [N] = '{32'h0000_0000, 32'h0000_0000, 32'h8000_0010, 32'h8000_0000};
  localparam logic [AW-1:0] TB_MASK [N] = '{32'hFFFC_0000, 32'hFFFF_F000, 32'hFFFF_FFF0, 32'hFFFF_FFF0};
  localparam logic [N*AW-1:0] P_BASE = {TB_BASE[3], TB_BASE[2], TB_BASE[1], TB_BASE[0]};
  localparam logic [N*AW-1:0] P_MASK = {TB_MASK[3], TB_MASK[2], TB_MASK[1], TB_MASK[0]};

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            bus_re = 1'b0;
  logic [DW/8-1:0] bus_we = '0;
  logic [AW-1:0]   bus_addr = '0;
  logic [DW-1:0]   bus_wdata = '0;
  logic [DW-1:0]   bus_rdata;
  logic            bus_stall;
  logic            bus_err;
  logic [N-1:0]    slv_ce;
  logic [DW/8-1:0] slv_we;
  logic [AW-1:0]   slv_addr;
  logic [DW-1:0]   slv_wdata;
  logic [N*DW-1:0] slv_rdata = '0;
  logic [N-1:0]    slv_ready;
`ifdef BUS_CTRL_STATS_EN
  logic [31:0]     stat_acc_cnt, stat_err_cnt;
`endif

  int          n_checks = 0;
  int          n_errors = 0;
  int          acc_cyc = 0;
  int          rdy_delay = 0;
  logic [N-1:0] noise = '0;
  int          exp_acc = 0;
  int          exp_errs = 0;

  bus_controller_mp #(
    .N_SLAVES    (N),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .SLV_BASE    (P_BASE),
    .SLV_MASK    (P_MASK),
    .TIMEOUT_CYC (TO),
    .ERR_DATA    (ERR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_re    (bus_re),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_stall (bus_stall),
    .bus_err   (bus_err),
    .slv_ce    (slv_ce),
    .slv_we    (slv_we),
    .slv_addr  (slv_addr),
    .slv_wdata (slv_wdata),
    .slv_rdata (slv_rdata),
`ifdef BUS_CTRL_STATS_EN
    .stat_acc_cnt (stat_acc_cnt),
    .stat_err_cnt (stat_err_cnt),
`endif
    .slv_ready (slv_ready)
  );

  always #5 clk = ~clk;

  // Slave model: the selected slave answers after rdy_delay ACCESS cycles;
  // unselected slaves may strobe ready at random and must be ignored.
  always_ff @(posedge clk) acc_cyc <= (|slv_ce) ? acc_cyc + 1 : 0;

  always_comb slv_ready = (slv_ce & {N{acc_cyc == rdy_delay}}) | (noise & ~slv_ce);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int model_decode(input logic [AW-1:0] a);
    for (int i = 0; i < N; i++) begin
      if ((a & TB_MASK[i]) == TB_BASE[i]) return i;
    end
    return -1;
  endfunction

  task automatic run_txn(input logic re, input logic [3:0] we, input logic [31:0] addr,
                         input logic [31:0] wd, input int dly, input logic [N-1:0] nz);
    int          sel, exp_stall, nstall;
    logic [31:0] exp_rd;
    logic        exp_err, done;
    logic [N-1:0] exp_ce;
    sel = model_decode(addr);
    exp_ce = '0;
    if (sel < 0) begin
      exp_stall = 1; exp_err = 1'b1; exp_rd = ERR;
    end else begin
      exp_ce[sel] = 1'b1;
      if (dly < TO) begin
        exp_stall = 2 + dly; exp_err = 1'b0; exp_rd = slv_rdata[sel*DW +: DW];
      end else begin
        exp_stall = 1 + TO; exp_err = 1'b1; exp_rd = ERR;
      end
    end
    @(negedge clk);
    rdy_delay = dly; noise = nz;
    bus_re = re; bus_we = we; bus_addr = addr; bus_wdata = wd;
    nstall = 0; done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      #1;
      if (!bus_stall) done = 1'b1;
      else begin
        if (nstall == 0) chk("idle_ce", slv_ce, '0);
        else begin
          chk("acc_ce", slv_ce, exp_ce);
          chk("acc_we", slv_we, we);
          chk("acc_addr", slv_addr, addr);
          chk("acc_wdata", slv_wdata, wd);
        end
        nstall++;
        @(negedge clk);
      end
    end
    chk("resp_seen", done, 1'b1);
    chk("stall_cycles", nstall, exp_stall);
    chk("resp_rdata", bus_rdata, exp_rd);
    chk("resp_err", bus_err, exp_err);
    chk("resp_ce", slv_ce, '0);
    exp_acc++;
    if (exp_err) exp_errs++;
    bus_re = 1'b0; bus_we = '0; noise = '0;
    @(negedge clk);
    #1;
    chk("hold_rdata", bus_rdata, exp_rd);
    chk("hold_err", bus_err, exp_err);
    chk("idle_stall", bus_stall, 1'b0);
  endtask

  initial begin
    logic [3:0]  we;
    logic        re;
    logic [31:0] a;
    int          dly;

    // Reset state, with a request pending to show stall is masked by rst.
    bus_re = 1'b1;
    #12;
    chk("rst_stall", bus_stall, 1'b0);
    chk("rst_ce", slv_ce, '0);
    chk("rst_we", slv_we, '0);
    chk("rst_addr", slv_addr, '0);
    chk("rst_wdata", slv_wdata, '0);
    chk("rst_rdata", bus_rdata, '0);
    chk("rst_err", bus_err, 1'b0);
    bus_re = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Zero-wait read from RAM; 0x40 also matches the alias region 1.
    slv_rdata[0*DW +: DW] = 32'h1234_5678;
    slv_rdata[1*DW +: DW] = 32'h0BAD_0BAD;
    run_txn(1'b1, 4'b0000, 32'h0000_0040, 32'h0, 0, '0);
    // Wait-state write to GPIOB.
    run_txn(1'b0, 4'b0011, 32'h8000_0014, 32'hA5A5_5A5A, 3, '0);
    // Decode miss.
    run_txn(1'b1, 4'b0000, 32'h4000_0000, 32'h0, 0, '0);
    // Timeout.
    run_txn(1'b1, 4'b0000, 32'h0000_1000, 32'h0, 99, '0);

    // Asynchronous reset in the middle of an access.
    @(negedge clk);
    rdy_delay = 99;
    bus_re = 1'b1; bus_addr = 32'h8000_0018;
    repeat (3) @(negedge clk);
    #1;
    chk("pre_rst_ce", slv_ce, 4'b0100);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_ce", slv_ce, '0);
    chk("async_rst_stall", bus_stall, 1'b0);
    chk("async_rst_rdata", bus_rdata, '0);
    chk("async_rst_err", bus_err, 1'b0);
    #1 rst = 1'b0;
    bus_re = 1'b0;
    exp_acc = 0; exp_errs = 0;
    run_txn(1'b1, 4'b0000, 32'h0000_0040, 32'h0, 1, '0);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      for (int s = 0; s < N; s++) slv_rdata[s*DW +: DW] = $urandom;
      case ($urandom_range(0, 4))
        0:       a = {14'd0, 18'($urandom)};
        1:       a = {20'd0, 12'($urandom)};
        2:       a = 32'h8000_0010 | 32'($urandom_range(0, 15));
        3:       a = 32'h8000_0000 | 32'($urandom_range(0, 15));
        default: a = 32'h4000_0000 | ($urandom & 32'h0FFF_FFFF);
      endcase
      we = 4'($urandom);
      re = 1'($urandom);
      if (!re && we == '0) re = 1'b1;
      dly = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 4);
      run_txn(re, we, a, $urandom, dly, 4'($urandom));
    end

`ifdef BUS_CTRL_STATS_EN
    #1;
    chk("stat_acc", stat_acc_cnt, 32'(exp_acc));
    chk("stat_err", stat_err_cnt, 32'(exp_errs));
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bus_controller_mp.md
Name: bus_controller_mp

Overview:
- Parametrised multi-port successor to the single-cycle core's chip-enable decoder.
- Sits between the CPU data bus and N memory-mapped slaves (RAM, GPIO banks, timers).
- Decodes the address through programmable base/mask regions and runs a registered request/ready handshake with each slave.
- Stalls the CPU until the slave is ready, returns registered read data, and flags decode misses and slave timeouts.

Parameters:
- N_SLAVES, 4, number of slave regions (1..16).
- ADDR_W, 32, address width.
- DATA_W, 32, data width (multiple of 8).
- SLV_BASE, {N_SLAVES*ADDR_W}, flat vector; region i base is at [i*ADDR_W +: ADDR_W].
- SLV_MASK, {N_SLAVES*ADDR_W}, flat vector; region i matches when (addr & mask_i) == base_i.
- TIMEOUT_CYC, 16, ACCESS cycles allowed before timeout (>=1).
- ERR_DATA, 32'hDEAD_BEEF, read data returned on an error (truncated or zero-extended to DATA_W).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- bus_re  in  1  CPU read request.
- bus_we  in  DATA_W/8  CPU byte write enables.
- bus_addr  in  ADDR_W  CPU address.
- bus_wdata  in  DATA_W  CPU write data.
- bus_rdata  out  DATA_W  registered read data.
- bus_stall  out  1  CPU must hold its request and not advance.
- bus_err  out  1  error flag, valid in the completion cycle.
- slv_ce  out  N_SLAVES  one-hot slave select, registered.
- slv_we  out  DATA_W/8  registered byte enables.
- slv_addr  out  ADDR_W  registered address.
- slv_wdata  out  DATA_W  registered write data.
- slv_rdata  in  N_SLAVES*DATA_W  flat slave read data.
- slv_ready  in  N_SLAVES  per-slave completion strobe.

Behaviour:
- Reset values:
  - state = IDLE.
  - slv_ce, slv_we, slv_addr, slv_wdata = 0.
  - bus_rdata = 0, bus_err = 0.
  - Timeout counter = 0.
  - bus_stall = 0 while rst is high.
- req = bus_re | (|bus_we). bus_stall = req & (state != RESP), computed combinationally.
- IDLE:
  - On req, decode the address. The lowest-index matching region wins.
  - Hit: latch addr/we/wdata into the slv_* registers, set slv_ce[sel] = 1, clear the counter, go to ACCESS.
  - Miss: set bus_err = 1, bus_rdata = ERR_DATA, go to RESP. No slv_ce is asserted.
- ACCESS:
  - slv_ce, slv_we, slv_addr and slv_wdata are held stable.
  - If slv_ready[sel] = 1: capture slv_rdata[sel] into bus_rdata, set bus_err = 0, clear slv_ce and slv_we, go to RESP.
  - Otherwise increment the counter. When counter == TIMEOUT_CYC-1 with no ready: set bus_rdata = ERR_DATA, bus_err = 1, clear slv_ce, go to RESP.
- RESP:
  - bus_stall = 0; the CPU retires the access this cycle.
  - Next state is IDLE unconditionally. No back-to-back pipelining: a new request is seen in IDLE.
- Latency from request-visible cycle (T0):
  - Decode hit with a zero-wait slave: ACCESS at T1, RESP at T2. The CPU is stalled for 2 cycles.
  - Decode miss: RESP at T1.
  - Timeout: RESP at T1+TIMEOUT_CYC.
- bus_rdata and bus_err hold their value until the next RESP entry.
- Read and write in the same request: treated as a write (slv_we = bus_we). Read data is still captured on ready.
- slv_ready on a non-selected slave: ignored. slv_ready seen in IDLE or RESP: ignored.
- CPU drops req during ACCESS: the slave transaction still completes. RESP is passed through and the result is discarded by the CPU.
- Asynchronous rst mid-ACCESS: slv_ce drops immediately and the state returns to IDLE. The slave must tolerate an aborted access.

Optional Feature:
- Macro: BUS_CTRL_STATS_EN.
- Defined:
  - Adds output ports stat_acc_cnt (32) and stat_err_cnt (32).
  - stat_acc_cnt increments on every RESP entry.
  - stat_err_cnt increments on every RESP entry with bus_err = 1.
  - Both counters saturate at 32'hFFFF_FFFF and are cleared by rst.
- Undefined: the ports and counter logic are absent. All other behaviour is identical.

Decomposition:
- Package bus_ctrl_pkg holds:
  - The state encoding (IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2).
  - The ERR_DATA default.
  - The system address-map constants (RAM base 0x0000_0000 with mask 0xFFFC_0000; GPIOA 0x8000_0000, GPIOB 0x8000_0010, both with mask 0xFFFF_FFF0).
- Sub-module bus_addr_decode is purely combinational: a priority base/mask match producing a one-hot sel plus a hit flag. It is instantiated once.

Test Plan:
- Zero-wait read: RAM region, ready tied to ce, read 0x0000_0040 returning 0x1234_5678 -> stall high for 2 cycles; RESP gives bus_rdata = 0x1234_5678, bus_err = 0.
- Wait-state write: GPIOB region, bus_we = 4'b0011 at 0x8000_0014, ready after 3 cycles -> slv_ce[2] high for 4 cycles; slv_we = 4'b0011 and slv_wdata stable throughout; RESP in cycle 5.
- Decode miss: read 0x4000_0000 -> RESP at T1; bus_err = 1, bus_rdata = 0xDEAD_BEEF; slv_ce never asserted.
- Timeout: TIMEOUT_CYC = 16, ready held low -> RESP at T17; bus_err = 1; slv_ce low from that edge on.
- Overlap, async reset and stats:
  - Overlapping regions 0 and 1 both match -> only slv_ce[0] asserts.
  - rst pulsed during ACCESS -> slv_ce drops without a clock edge; next request behaves normally.
- Stats, with BUS_CTRL_STATS_EN defined: 3 good accesses and 1 miss -> stat_acc_cnt = 4, stat_err_cnt = 1.
